// File: rtl/mem_arb_pkg.sv
// Shared types for the SPI/local-master register RAM arbiter.
// Command struct and FSM state encoding used by the arbiter and the bench.
package mem_arb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/spi_mem_arbiter_rr_picker.sv
// Round-robin winner select: first set request at or after ptr, wrapping.
// Purely combinational, zero latency; no backpressure of its own.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_vld
);

  logic [IDX_W:0] cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!win_vld && req[cand[IDX_W-1:0]]) begin
        win_vld                 = 1'b1;
        win_idx                 = cand[IDX_W-1:0];
        win_oh[cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing one 1024x32 RAM; write strobe 1 cycle after req, read rsp 2+READ_LAT.
// One transaction in flight, req ignored while busy; MEM_ARB_STATS_EN adds saturating grant counters.
module spi_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       mem_r_en,
  output logic                       mem_w_en,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data_o,
  input  logic [DATA_W-1:0]          mem_data_i,
  output logic                       busy,
  output logic [NUM_REQ*CNT_W-1:0]   grant_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WC_W  = 2;

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic [WC_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 mem_r_en_q, mem_r_en_d;
  logic                 mem_w_en_q, mem_w_en_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_data_o_q, mem_data_o_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_vld;
  cmd_t                 sel_cmd;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  always_comb begin
    sel_cmd.we    = req_we[pick_idx];
    sel_cmd.addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
    sel_cmd.wdata = req_wdata[pick_idx*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    wait_cnt_d   = wait_cnt_q;
    gnt_d        = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    mem_r_en_d   = 1'b0;
    mem_w_en_d   = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_o_d = mem_data_o_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = ISSUE;
          win_d      = pick_idx;
          gnt_d      = pick_oh;
          mem_w_en_d = sel_cmd.we;
          mem_r_en_d = !sel_cmd.we;
          mem_addr_d = sel_cmd.addr;
          // Write data bus only moves for writes, reads leave it parked.
          if (sel_cmd.we) begin
            mem_data_o_d = sel_cmd.wdata;
          end
        end
      end
      ISSUE: begin
        ptr_d = (win_q == IDX_W'(NUM_REQ-1)) ? '0 : win_q + IDX_W'(1);
        if (mem_r_en_q) begin
          state_d    = WAIT;
          wait_cnt_d = WC_W'(READ_LAT-1);
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d     = RESP;
          rsp_rdata_d = mem_data_i;
          rsp_valid_d = NUM_REQ'(1) << win_q;
        end else begin
          wait_cnt_d = wait_cnt_q - WC_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      wait_cnt_q   <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_o_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      wait_cnt_q   <= wait_cnt_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      mem_r_en_q   <= mem_r_en_d;
      mem_w_en_q   <= mem_w_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_o_q <= mem_data_o_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign mem_r_en   = mem_r_en_q;
  assign mem_w_en   = mem_w_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data_o = mem_data_o_q;
  assign busy       = busy_q;

`ifdef MEM_ARB_STATS_EN
  logic [NUM_REQ*CNT_W-1:0] cnt_q, cnt_d;

  // Counts track gnt_d so the count moves in the same cycle gnt is seen.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_d[i] && (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
        cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`else
  assign grant_cnt = '0;
`endif

endmodule
